// File: rtl/fifo_proc_sched.sv
// fifo_proc_sched
// Sequencing controller in front of the input sample FIFO.
//   - BOOT counts 2^RST_CNT_W-1 clocks, RELEASE pulses rst_proc for one cycle,
//     then RUN (terminal until reset).
//   - In RUN, paces source samples into the FIFO once every max(period,1)
//     cycles, throttled by fifo_full or the high watermark.
//   - In RUN, arbitrates FIFO reads between main core (bit0) and DTW core
//     (bit1) with round-robin priority and a mandatory idle cycle per grant.
//
// State table:
//   state   | meaning
//   BOOT    | boot counter running, no FIFO traffic
//   RELEASE | one cycle, rst_proc high, period counter loads
//   RUN     | paced writes and arbitrated reads
//
// Ports:
//   clk, rst_geral            clock, async active-high reset
//   src_data/valid/ready      streaming source handshake (ready = consume pulse)
//   period                    write period in cycles (0 behaves as 1)
//   fifo_data/wrreq           registered write data and write pulse
//   fifo_full/empty/usedw     FIFO status
//   fifo_rdreq, gnt           read pulse and one-hot grant (bit0 main, bit1 DTW)
//   req_in                    read requests
//   rst_proc                  processor-release pulse
//   state                     0 BOOT, 1 RELEASE, 2 RUN
//   stall_cnt                 saturating count of blocked write ticks
module fifo_proc_sched #(
  parameter int DW        = 16,
  parameter int RST_CNT_W = 14,
  parameter int USEDW_W   = 7,
  parameter int PERIOD_W  = 16,
  parameter int HI_WM     = 120
) (
  input  logic                clk,
  input  logic                rst_geral,
  input  logic [DW-1:0]       src_data,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [PERIOD_W-1:0] period,
  output logic [DW-1:0]       fifo_data,
  output logic                fifo_wrreq,
  input  logic                fifo_full,
  input  logic                fifo_empty,
  input  logic [USEDW_W-1:0]  fifo_usedw,
  output logic                fifo_rdreq,
  input  logic [1:0]          req_in,
  output logic [1:0]          gnt,
  output logic                rst_proc,
  output logic [1:0]          state,
  output logic [15:0]         stall_cnt
);

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [31:0] HI_WM_U  = HI_WM;

  logic [RST_CNT_W-1:0] boot_cnt;
  logic [PERIOD_W-1:0]  per_cnt;
  logic [PERIOD_W-1:0]  period_eff;
  logic                 rr_ptr;     // 0 favours main core, 1 favours DTW core
  logic                 tick;
  logic                 wr_ok;
  logic                 rd_go;
  logic                 winner;

  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign tick       = (state == S_RUN) && (per_cnt == PERIOD_W'(1));
  assign wr_ok      = !fifo_full && (32'(fifo_usedw) < HI_WM_U);
  // fifo_rdreq high means the grant cycle is in progress: the next cycle is idle.
  assign rd_go      = (state == S_RUN) && !fifo_rdreq && !fifo_empty && (req_in != 2'b00);
  assign winner     = (req_in == 2'b11) ? rr_ptr : req_in[1];

  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      state      <= S_BOOT;
      boot_cnt   <= '0;
      per_cnt    <= '0;
      rst_proc   <= 1'b0;
      src_ready  <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      stall_cnt  <= '0;
      fifo_rdreq <= 1'b0;
      gnt        <= 2'b00;
      rr_ptr     <= 1'b0;
    end else begin
      rst_proc   <= 1'b0;
      src_ready  <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_rdreq <= 1'b0;
      gnt        <= 2'b00;

      case (state)
        S_BOOT: begin
          if (boot_cnt == '1) begin
            state    <= S_RELEASE;
            rst_proc <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          state   <= S_RUN;
          per_cnt <= period_eff;
        end
        default: ;
      endcase

      if (state == S_RUN) begin
        if (tick) begin
          per_cnt <= period_eff;
          if (src_valid) begin
            if (wr_ok) begin
              fifo_wrreq <= 1'b1;
              fifo_data  <= src_data;
              src_ready  <= 1'b1;
            end else if (stall_cnt != 16'hFFFF) begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end else begin
          per_cnt <= per_cnt - 1'b1;
        end

        if (rd_go) begin
          fifo_rdreq <= 1'b1;
          gnt        <= winner ? 2'b10 : 2'b01;
          rr_ptr     <= ~winner;
        end
      end
    end
  end

endmodule

// File: doc/fifo_proc_sched.md
Name: fifo_proc_sched

Overview:
- Sequencing controller in front of the input sample FIFO of top_level.
- Generates the processor-release pulse after a boot count.
- Paces sample writes from a streaming source into the FIFO at a programmable period.
- Arbitrates FIFO reads between the two processor requesters (main core, DTW core) with round-robin priority.

Parameters:
- DW, 16, sample width (signed, passed through untouched)
- RST_CNT_W, 14, boot counter width; rst_proc fires at count 2^RST_CNT_W-1
- USEDW_W, 7, FIFO fill-level width
- PERIOD_W, 16, write-period register width
- HI_WM, 120, fill level at/above which writes are throttled

Ports:
- clk  in  1  system clock
- rst_geral  in  1  asynchronous, active-high reset
- src_data  in  DW  sample from source
- src_valid  in  1  source has a sample
- src_ready  out  1  one-cycle pulse: sample consumed this cycle
- period  in  PERIOD_W  cycles between writes; 0 treated as 1
- fifo_data  out  DW  registered write data
- fifo_wrreq  out  1  one-cycle write pulse
- fifo_full  in  1  FIFO full
- fifo_empty  in  1  FIFO empty
- fifo_usedw  in  USEDW_W  FIFO fill level
- fifo_rdreq  out  1  one-cycle read pulse
- req_in  in  2  read requests; bit0 main core, bit1 DTW core
- gnt  out  2  one-hot grant, valid with fifo_rdreq; q is valid to the granted core on the next cycle
- rst_proc  out  1  one-cycle processor-release pulse
- state  out  2  0 BOOT, 1 RELEASE, 2 RUN
- stall_cnt  out  16  saturating count of write ticks blocked by full or watermark

Behaviour:
- All outputs are registered.
- Reset values: src_ready=0, fifo_data=0, fifo_wrreq=0, fifo_rdreq=0, gnt=00, rst_proc=0, state=BOOT, stall_cnt=0. The round-robin pointer resets to favour bit0.
- Reset is honoured mid-operation: all state clears immediately. Any pulse in flight is cut.

State machine:
- BOOT: boot counter increments every clk from 0. No writes, reads or grants.
  - At count 2^RST_CNT_W-1 (16383 at default), go to RELEASE.
- RELEASE: exactly one cycle. rst_proc=1. The period counter loads. Next state is RUN.
- RUN: terminal until reset. rst_proc never re-fires.

Write path (RUN only):
- Period counter: tick asserted every max(period,1) cycles. The first tick occurs max(period,1) cycles after entering RUN.
- period changes take effect at the next reload.
- On a tick with src_valid=1, fifo_full=0 and fifo_usedw<HI_WM, in the next cycle:
  - fifo_wrreq=1
  - fifo_data=src_data as sampled at the tick
  - src_ready=1
- On a tick with src_valid=1 and (fifo_full=1 or fifo_usedw>=HI_WM): no write, src_ready=0, stall_cnt increments (saturates at 0xFFFF). The sample is held by the source and retried at the next tick.
- On a tick with src_valid=0: nothing happens. The tick is lost, not accumulated.

Read arbiter (RUN only):
- Requires fifo_empty=0 and req_in!=00. In the next cycle, fifo_rdreq=1 and gnt is one-hot.
- Single request: that requester is granted.
- Both requesting: the pointer side wins. The pointer then moves to the other side. A single-request grant also moves the pointer away from the granted side.
- After a grant there is one mandatory idle cycle (no rdreq). This gives the requester time to drop req_in; a request still high after that is treated as a new one.
- With fifo_empty=1, requests are held pending with no grant. The pointer does not change.

Concurrency and width rules:
- A write and a read in the same cycle are allowed and independent.
- fifo_full and fifo_empty are sampled in the same cycle as the decision.
- No arithmetic is performed on data.
- Counters wrap only where stated: the boot counter stops at max, stall_cnt saturates.

Test Plan:
- Reset release, hold all inputs idle → rst_proc pulses high for exactly 1 cycle at cycle 16384 after reset deassertion; state reads 0, then 1, then 2; no wrreq or rdreq before that point.
- RUN, period=4, src_valid=1 with data ramp 1,2,3… → fifo_wrreq every 4 cycles carrying 1,2,3 in order; src_ready coincident with each wrreq.
- RUN, period=0 → a write occurs every cycle. Then force fifo_usedw=120 → writes stop and stall_cnt increments once per cycle; drop usedw to 119 → writes resume with the held sample (no loss or duplication).
- fifo_empty=0, req_in=11 held → gnt sequence 01, idle, 10, idle, 01, …; with req_in=10 only → gnt 10 every other cycle.
- fifo_empty=1 with req_in=01 for 10 cycles → no rdreq; release empty → rdreq and gnt=01 on the next cycle.
- Assert rst_geral mid-RUN during a wrreq pulse → all outputs are 0 immediately, state returns to BOOT, and rst_proc re-fires after 16384 cycles.
